dacx0504_spi_ctrl: RTL and testbench
====================================

# dacx0504_spi_ctrl

SPI master that drives the DACx0504 serial port from the 100 MHz system domain. It accepts single-register write/read commands from the control logic, serialises 24-bit frames onto DAC_CLK/DAC_SDI/DAC_CS_N, and returns readback data captured from DAC_SDO. It sits directly upstream of the DAC device, or of its simulation model in benches, and is the only agent on that bus.

## Interface
- CLK_DIV, 4: SYS_CLK cycles per DAC_CLK half-period (4 gives 12.5 MHz); must be ≥2.
- CS_GAP, 2: minimum whole DAC_CLK periods with DAC_CS_N high between frames; must be ≥2.
- SYS_CLK  in  1  100 MHz system clock; the only clock.
- SYS_RST  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
- cmd_rd  in  1  1 = read, 0 = write.
- cmd_addr  in  4  register address.
- cmd_wdata  in  16  write data; ignored for reads.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  16  readback data; 0 for writes.
- rsp_err  out  1  readback header mismatch (see Configuration).
- busy  out  1  high from acceptance until the rsp_valid cycle, inclusive.
- DAC_CLK  out  1  free-running serial clock, registered.
- DAC_SDI  out  1  serial data to device, MSB first.
- DAC_CS_N  out  1  active-low frame select.
- DAC_SDO  in  1  serial data from device.

## Operation
- Reset values: DAC_CLK=0, DAC_CS_N=1, DAC_SDI=0, cmd_ready=0 during reset and 1 in the first cycle after it, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0. The divider counter clears to 0.
- DAC_CLK toggles every CLK_DIV cycles, never stops, and continues during CS gaps. The device loads readback while CS is high, so the clock must run then.
- Frame formats: write {1'b0, 3'b000, addr, wdata}; read command {1'b1, 3'b000, addr, 16'h0000}; NOP 24'h000000.
- Frame: DAC_CS_N falls on a DAC_CLK falling edge, and DAC_CS_N stays low for exactly 25 DAC_CLK periods.
  - Period 0 is the lead-in: SDI=0, and the device ignores the first rising edge.
  - Periods 1..24 carry frame bits 23..0.
- DAC_SDI changes only on DAC_CLK falling edges, in the same SYS_CLK cycle as the edge.
- DAC_SDO is sampled in the SYS_CLK cycle that drives DAC_CLK 0→1 for periods 1..24, so it is sampled before the device shifts. The 24 samples form capture[23:0], MSB first.
- FSM: IDLE → LEAD → SHIFT → GAP → (second frame for reads: LEAD → SHIFT → GAP) → RESP → IDLE.
  - Write: one frame.
  - Read: a command frame, then a NOP frame. The capture from the NOP frame is the response.
- RESP lasts one cycle:
  - rsp_valid=1.
  - rsp_rdata=capture[15:0] for reads, 0 for writes.
  - rsp_err is computed from the capture (see Configuration).
- rsp_rdata and rsp_err hold their values until the next RESP.
- Command fields are registered at acceptance. Later changes on the inputs have no effect on the transaction in flight.
- SYS_RST mid-frame: DAC_CS_N=1 in the cycle after reset is sampled, the transaction is dropped, and no rsp_valid is issued.

## Timing
- From acceptance to DAC_CS_N falling: at most 2·CLK_DIV cycles, waiting for the next falling edge.
- DAC_CS_N low time is 25·2·CLK_DIV cycles (200 cycles at default).
- GAP holds DAC_CS_N high for CS_GAP full DAC_CLK periods (16 cycles at default) after each frame, before the next frame or RESP.
- rsp_valid rises in the cycle after GAP ends.
  - Write: at most 16+200+16+1 cycles after acceptance.
  - Read: at most 16+2·(200+16)+1 cycles after acceptance.
- cmd_ready returns high in the cycle after rsp_valid, so back-to-back commands always respect CS_GAP.
- Simultaneous cmd_valid and SYS_RST: reset wins and the command is not accepted.

## Configuration
- DAC_RDCHK_EN defined: for reads, rsp_err=1 when capture[23:20]≠4'h8 or capture[19:16]≠cmd_addr; writes always give rsp_err=0.
- DAC_RDCHK_EN undefined: rsp_err is tied to 0 and the check logic is absent. rsp_rdata behaviour is unchanged.

## Test plan
- Read addr 4'h1 against the device model → rsp_rdata=16'hABCD, rsp_err=0; SDI frames are 24'h810000 then 24'h000000.
- Read addr 4'hA → rsp_rdata=16'h5566, rsp_err=0; DAC_CS_N is high for ≥16 cycles between the two frames.
- Write addr 4'h8, data 16'h1234 → a single frame 24'h081234 on SDI, 25 DAC_CLK periods with CS low, then rsp_valid with rsp_rdata=0.
- Read addr 4'hC, where the model returns 0 → rsp_rdata=0; rsp_err=1 with DAC_RDCHK_EN, 0 without.
- Two commands presented back-to-back with cmd_valid held high → second accepted only after the first rsp_valid; no CS overlap; both responses correct.
- SYS_RST pulsed at SHIFT period 10 → DAC_CS_N=1 on the next cycle, no rsp_valid; a subsequent read of addr 4'h1 still returns 16'hABCD.

Source files
------------

// File: rtl/dacx0504_spi_ctrl.sv
// -----------------------------------------------------------------------------
// dacx0504_spi_ctrl
//
// SPI master for the DACx0504 serial port. Accepts one register write or read
// per command, shifts 24-bit frames out on DAC_SDI (MSB first), and returns
// readback data captured from DAC_SDO. A read is a command frame followed by a
// NOP frame. The NOP frame's capture is the response.
//
// Optional feature macro: DAC_RDCHK_EN
//   defined   : reads check the readback header (capture[23:20] == 4'h8 and
//               capture[19:16] == address) and flag a mismatch on rsp_err.
//   undefined : rsp_err is tied to 0 and only the 16 data bits are captured.
//
// Parameters
//   CLK_DIV   SYS_CLK cycles per DAC_CLK half-period (>= 2)
//   CS_GAP    whole DAC_CLK periods with DAC_CS_N high between frames (>= 2)
//
// Ports
//   SYS_CLK, SYS_RST           system clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_rd, cmd_addr, cmd_wdata command fields, registered at acceptance
//   rsp_valid                  one-cycle completion pulse
//   rsp_rdata, rsp_err         readback data / header error, held until next
//   busy                       transaction in flight (through the rsp cycle)
//   DAC_CLK, DAC_SDI, DAC_CS_N serial outputs to the device
//   DAC_SDO                    serial data from the device
//
// State | meaning
//   IDLE  | waiting for a command, cmd_ready high
//   LEAD  | CS high: wait for a DAC_CLK fall to drop CS; CS low: lead-in period
//   SHIFT | periods 1..24, one frame bit per period, SDO sampled on rises
//   GAP   | CS high for CS_GAP periods; then next frame (reads) or RESP
//   RESP  | one-cycle rsp_valid
// -----------------------------------------------------------------------------
module dacx0504_spi_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic        SYS_CLK,
  input  logic        SYS_RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rd,
  input  logic [3:0]  cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        DAC_CLK,
  output logic        DAC_SDI,
  output logic        DAC_CS_N,
  input  logic        DAC_SDO
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(CS_GAP);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_GAP - 1);

`ifdef DAC_RDCHK_EN
  localparam int CAP_W = 24;
`else
  // Without the header check only the last 16 samples matter.
  localparam int CAP_W = 16;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_GAP,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [DIV_W-1:0]  r_div_cnt;
  logic              r_dac_clk;
  logic              w_tick;
  logic              w_rise;
  logic              w_fall;

  logic              r_cs_n;
  logic              r_sdi;
  logic [23:0]       r_frame;
  logic [CAP_W-1:0]  r_capture;
  logic [4:0]        r_bit_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              r_rd;
  logic              r_second;
  logic [15:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic              w_accept;
  logic              w_rd_err;

  // Free-running serial clock; keeps toggling through CS gaps because the
  // device loads readback data while CS is high.
  assign w_tick = (r_div_cnt == DIV_LAST);
  assign w_rise = w_tick && !r_dac_clk;
  assign w_fall = w_tick &&  r_dac_clk;

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      r_div_cnt <= '0;
      r_dac_clk <= 1'b0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_dac_clk <= ~r_dac_clk;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Gating with SYS_RST makes reset win over a simultaneous cmd_valid.
  assign cmd_ready = (r_state == S_IDLE) && !SYS_RST;
  assign w_accept  = cmd_valid && cmd_ready;
  assign rsp_valid = (r_state == S_RESP);
  assign busy      = (r_state != S_IDLE);

  assign DAC_CLK   = r_dac_clk;
  assign DAC_SDI   = r_sdi;
  assign DAC_CS_N  = r_cs_n;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

`ifdef DAC_RDCHK_EN
  logic [3:0] r_addr;

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      r_addr <= 4'h0;
    end else if (w_accept) begin
      r_addr <= cmd_addr;
    end
  end

  assign w_rd_err = r_rd && ((r_capture[23:20] != 4'h8) || (r_capture[19:16] != r_addr));
`else
  assign w_rd_err = 1'b0;
`endif

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_LEAD;
      S_LEAD:  if (w_fall && !r_cs_n) w_next = S_SHIFT;
      S_SHIFT: if (w_fall && (r_bit_cnt == 5'd0)) w_next = S_GAP;
      S_GAP: begin
        if (w_fall && (r_gap_cnt == '0)) begin
          w_next = (r_rd && !r_second) ? S_LEAD : S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      r_cs_n      <= 1'b1;
      r_sdi       <= 1'b0;
      r_frame     <= 24'h0;
      r_capture   <= '0;
      r_bit_cnt   <= 5'd0;
      r_gap_cnt   <= '0;
      r_rd        <= 1'b0;
      r_second    <= 1'b0;
      r_rsp_rdata <= 16'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rd     <= cmd_rd;
            r_second <= 1'b0;
            r_frame  <= {cmd_rd, 3'b000, cmd_addr, (cmd_rd ? 16'h0000 : cmd_wdata)};
          end
        end
        S_LEAD: begin
          if (w_fall) begin
            if (r_cs_n) begin
              // Open the frame; the following period is the lead-in.
              r_cs_n <= 1'b0;
              r_sdi  <= 1'b0;
            end else begin
              r_sdi     <= r_frame[23];
              r_frame   <= {r_frame[22:0], 1'b0};
              r_bit_cnt <= 5'd23;
            end
          end
        end
        S_SHIFT: begin
          if (w_rise) begin
            r_capture <= {r_capture[CAP_W-2:0], DAC_SDO};
          end
          if (w_fall) begin
            if (r_bit_cnt == 5'd0) begin
              r_cs_n    <= 1'b1;
              r_sdi     <= 1'b0;
              r_gap_cnt <= GAP_LOAD;
            end else begin
              r_sdi     <= r_frame[23];
              r_frame   <= {r_frame[22:0], 1'b0};
              r_bit_cnt <= r_bit_cnt - 5'd1;
            end
          end
        end
        S_GAP: begin
          if (w_fall) begin
            if (r_gap_cnt == '0) begin
              if (r_rd && !r_second) begin
                // Read: the NOP frame starts on this same falling edge.
                r_second <= 1'b1;
                r_frame  <= 24'h000000;
                r_cs_n   <= 1'b0;
                r_sdi    <= 1'b0;
              end else begin
                r_rsp_rdata <= r_rd ? r_capture[15:0] : 16'h0000;
                r_rsp_err   <= w_rd_err;
              end
            end else begin
              r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dacx0504_spi_ctrl.sv
`timescale 1ns/1ps
module tb_dacx0504_spi_ctrl;

  logic        SYS_CLK = 1'b0;
  logic        SYS_RST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_rd = 1'b0;
  logic [3:0]  cmd_addr = 4'h0;
  logic [15:0] cmd_wdata = 16'h0;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        DAC_CLK;
  logic        DAC_SDI;
  logic        DAC_CS_N;
  logic        DAC_SDO;

  int checks = 0;
  int errors = 0;

`ifdef DAC_RDCHK_EN
  localparam bit RDCHK = 1'b1;
`else
  localparam bit RDCHK = 1'b0;
`endif

  dacx0504_spi_ctrl #(.CLK_DIV(4), .CS_GAP(2)) dut (
    .SYS_CLK   (SYS_CLK),
    .SYS_RST   (SYS_RST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rd    (cmd_rd),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .DAC_CLK   (DAC_CLK),
    .DAC_SDI   (DAC_SDI),
    .DAC_CS_N  (DAC_CS_N),
    .DAC_SDO   (DAC_SDO)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  // ---------------- device model ----------------
  logic [23:0] m_in = 24'h0;
  logic [23:0] m_out = 24'h0;
  int          m_rises = 0;
  logic [15:0] m_regs [16];

  assign DAC_SDO = m_out[23];

  logic [23:0] obs_frames[$];
  int          obs_periods[$];
  int          obs_low[$];
  int          obs_high[$];
  logic [23:0] exp_frames[$];
  logic [16:0] exp_rsp[$];     // {rdata, err}
  logic [15:0] sb_regs [16];

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_regs[i]  = 16'h0;
      sb_regs[i] = 16'h0;
    end
    m_regs[1]   = 16'hABCD;
    m_regs[10]  = 16'h5566;
    sb_regs[1]  = 16'hABCD;
    sb_regs[10] = 16'h5566;
  end

  always @(negedge DAC_CS_N) m_rises = 0;

  // First rise of a frame is ignored; later rises sample SDI then shift SDO.
  always @(posedge DAC_CLK) begin
    if (DAC_CS_N === 1'b0) begin
      if (m_rises > 0) begin
        m_in  = {m_in[22:0], DAC_SDI};
        m_out = {m_out[22:0], 1'b0};
      end
      m_rises++;
    end
  end

  always @(posedge DAC_CS_N) begin
    if (m_rises > 0) begin
      obs_frames.push_back(m_in);
      obs_periods.push_back(m_rises);
      if (m_rises == 25) begin
        if (m_in[23]) begin
          m_out = (m_in[19:16] == 4'hC) ? 24'h000000 : {4'h8, m_in[19:16], m_regs[m_in[19:16]]};
        end else if (m_in != 24'h000000) begin
          m_regs[m_in[19:16]] = m_in[15:0];
        end
      end
      m_rises = 0;
    end
  end

  // CS low/high run lengths in SYS_CLK cycles.
  logic mon_prev = 1'b1;
  int   mon_run = 0;
  bit   mon_had = 1'b0;
  always @(negedge SYS_CLK) begin
    if (SYS_RST) begin
      mon_prev = 1'b1;
      mon_run  = 0;
      mon_had  = 1'b0;
    end else if (DAC_CS_N !== mon_prev) begin
      if (mon_prev == 1'b0) begin
        obs_low.push_back(mon_run);
        mon_had = 1'b1;
      end else if (mon_had) begin
        obs_high.push_back(mon_run);
      end
      mon_prev = DAC_CS_N;
      mon_run  = 1;
    end else begin
      mon_run++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic push_expect(input logic rd, input logic [3:0] a, input logic [15:0] d);
    if (rd) begin
      exp_frames.push_back({1'b1, 3'b000, a, 16'h0000});
      exp_frames.push_back(24'h000000);
      if (a == 4'hC) exp_rsp.push_back({16'h0000, RDCHK});
      else           exp_rsp.push_back({sb_regs[a], 1'b0});
    end else begin
      exp_frames.push_back({1'b0, 3'b000, a, d});
      exp_rsp.push_back({16'h0000, 1'b0});
      sb_regs[a] = d;
    end
  endtask

  task automatic issue(input logic rd, input logic [3:0] a, input logic [15:0] d, output time t_acc);
    int n;
    n = 0;
    @(negedge SYS_CLK);
    while (cmd_ready !== 1'b1 && n < 3000) begin
      @(negedge SYS_CLK);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_rd    = rd;
    cmd_addr  = a;
    cmd_wdata = d;
    push_expect(rd, a, d);
    @(posedge SYS_CLK);
    t_acc = $time;
    #1;
    // Scramble the inputs: the transaction must use the registered fields.
    cmd_valid = 1'b0;
    cmd_rd    = 1'($urandom);
    cmd_addr  = 4'($urandom);
    cmd_wdata = 16'($urandom);
  endtask

  task automatic wait_rsp(input string name, input time t_acc, input int bound);
    int n;
    int lat;
    logic [16:0] e;
    n = 0;
    @(negedge SYS_CLK);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_in_flight got %b want 1", name, busy);
    end
    while (rsp_valid !== 1'b1 && n < 2000) begin
      @(negedge SYS_CLK);
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s rsp_timeout got %b want 1", name, rsp_valid);
      return;
    end
    e = (exp_rsp.size() > 0) ? exp_rsp.pop_front() : 17'h1FFFF;
    checks++;
    if (rsp_rdata !== e[16:1]) begin
      errors++;
      $display("FAIL %s rdata got %h want %h", name, rsp_rdata, e[16:1]);
    end
    checks++;
    if (rsp_err !== e[0]) begin
      errors++;
      $display("FAIL %s err got %b want %b", name, rsp_err, e[0]);
    end
    lat = int'(($time - t_acc - 5) / 10) + 1;
    checks++;
    if (lat > bound || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s latency got %0d busy %b want <=%0d busy 1", name, lat, busy, bound);
    end
    @(negedge SYS_CLK);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_rsp got valid %b ready %b busy %b want 0 1 0", name, rsp_valid, cmd_ready, busy);
    end
  endtask

  task automatic check_frames(input string name, input int nf);
    logic [23:0] ef;
    logic [23:0] of;
    int          op;
    int          lo;
    int          hi;
    for (int i = 0; i < nf; i++) begin
      checks++;
      if (obs_frames.size() == 0 || exp_frames.size() == 0 || obs_low.size() == 0) begin
        errors++;
        $display("FAIL %s frame_missing got %0d want %0d", name, obs_frames.size(), nf);
      end else begin
        ef = exp_frames.pop_front();
        of = obs_frames.pop_front();
        op = obs_periods.pop_front();
        lo = obs_low.pop_front();
        if (of !== ef) begin
          errors++;
          $display("FAIL %s frame%0d got %h want %h", name, i, of, ef);
        end
        checks++;
        if (op != 25 || lo != 200) begin
          errors++;
          $display("FAIL %s cs_low%0d got %0d periods %0d cycles want 25 200", name, i, op, lo);
        end
      end
    end
    while (obs_high.size() > 0) begin
      hi = obs_high.pop_front();
      checks++;
      if (hi < 16) begin
        errors++;
        $display("FAIL %s cs_gap got %0d want >=16", name, hi);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int toggles;
    logic last;
    cmd_valid = 1'b1;
    cmd_rd    = 1'b0;
    cmd_addr  = 4'h5;
    cmd_wdata = 16'hFFFF;
    repeat (6) @(negedge SYS_CLK);
    checks++;
    if (DAC_CS_N !== 1'b1 || DAC_CLK !== 1'b0 || DAC_SDI !== 1'b0) begin
      errors++;
      $display("FAIL reset_pins got cs %b clk %b sdi %b want 1 0 0", DAC_CS_N, DAC_CLK, DAC_SDI);
    end
    checks++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got ready %b valid %b busy %b want 0 0 0", cmd_ready, rsp_valid, busy);
    end
    checks++;
    if (rsp_rdata !== 16'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp got %h %b want 0000 0", rsp_rdata, rsp_err);
    end
    cmd_valid = 1'b0;
    SYS_RST   = 1'b0;
    @(negedge SYS_CLK);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || DAC_CS_N !== 1'b1) begin
      errors++;
      $display("FAIL post_reset got ready %b busy %b cs %b want 1 0 1", cmd_ready, busy, DAC_CS_N);
    end
    toggles = 0;
    last = DAC_CLK;
    for (int i = 0; i < 32; i++) begin
      @(negedge SYS_CLK);
      if (DAC_CLK !== last) toggles++;
      last = DAC_CLK;
    end
    checks++;
    if (toggles != 8) begin
      errors++;
      $display("FAIL dac_clk_rate got %0d toggles want 8", toggles);
    end
  endtask

  task automatic test_read(input logic [3:0] a, input string name);
    time t;
    issue(1'b1, a, 16'h0, t);
    wait_rsp(name, t, 449);
    check_frames(name, 2);
  endtask

  task automatic test_write;
    time t;
    issue(1'b0, 4'h8, 16'h1234, t);
    wait_rsp("write_a8", t, 233);
    check_frames("write_a8", 1);
  endtask

  task automatic test_hold;
    repeat (30) @(negedge SYS_CLK);
    checks++;
    if (rsp_rdata !== 16'h5566 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL rsp_hold got %h %b want 5566 0", rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int nrsp;
    logic [16:0] e;
    n = 0;
    nrsp = 0;
    @(negedge SYS_CLK);
    while (cmd_ready !== 1'b1 && n < 3000) begin
      @(negedge SYS_CLK);
      n++;
    end
    cmd_valid = 1'b1;
    cmd_rd    = 1'b1;
    cmd_addr  = 4'h8;
    push_expect(1'b1, 4'h8, 16'h0);
    @(posedge SYS_CLK);
    #1;
    cmd_addr = 4'h1;
    push_expect(1'b1, 4'h1, 16'h0);
    n = 0;
    while (n < 3000 && nrsp < 2) begin
      @(negedge SYS_CLK);
      n++;
      if (rsp_valid === 1'b1) begin
        nrsp++;
        e = (exp_rsp.size() > 0) ? exp_rsp.pop_front() : 17'h1FFFF;
        checks++;
        if (rsp_rdata !== e[16:1] || rsp_err !== e[0]) begin
          errors++;
          $display("FAIL b2b_rsp%0d got %h %b want %h %b", nrsp, rsp_rdata, rsp_err, e[16:1], e[0]);
        end
      end
      if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
        checks++;
        if (nrsp != 1) begin
          errors++;
          $display("FAIL b2b_accept got %0d responses want 1", nrsp);
        end
        @(posedge SYS_CLK);
        #1;
        cmd_valid = 1'b0;
        cmd_addr  = 4'h3;
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (nrsp != 2) begin
      errors++;
      $display("FAIL b2b_count got %0d want 2", nrsp);
    end
    check_frames("b2b", 4);
  endtask

  task automatic test_reset_mid;
    int n;
    int nvalid;
    int ncs;
    n = 0;
    @(negedge SYS_CLK);
    while (cmd_ready !== 1'b1 && n < 3000) begin
      @(negedge SYS_CLK);
      n++;
    end
    cmd_valid = 1'b1;
    cmd_rd    = 1'b1;
    cmd_addr  = 4'h1;
    @(posedge SYS_CLK);
    #1;
    cmd_valid = 1'b0;
    n = 0;
    while (DAC_CS_N !== 1'b0 && n < 100) begin
      @(negedge SYS_CLK);
      n++;
    end
    while (m_rises < 11 && n < 300) begin
      @(negedge SYS_CLK);
      n++;
    end
    checks++;
    if (m_rises < 11) begin
      errors++;
      $display("FAIL mid_reach got %0d rises want 11", m_rises);
    end
    SYS_RST = 1'b1;
    @(negedge SYS_CLK);
    checks++;
    if (DAC_CS_N !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got cs %b busy %b valid %b want 1 0 0", DAC_CS_N, busy, rsp_valid);
    end
    @(negedge SYS_CLK);
    @(negedge SYS_CLK);
    SYS_RST = 1'b0;
    nvalid = 0;
    ncs = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge SYS_CLK);
      if (rsp_valid === 1'b1) nvalid++;
      if (DAC_CS_N !== 1'b1) ncs++;
    end
    checks++;
    if (nvalid != 0 || ncs != 0) begin
      errors++;
      $display("FAIL mid_dropped got %0d rsp %0d cs_low want 0 0", nvalid, ncs);
    end
    obs_frames.delete();
    obs_periods.delete();
    obs_low.delete();
    obs_high.delete();
    exp_frames.delete();
    exp_rsp.delete();
    test_read(4'h1, "read_a1_after_reset");
  endtask

  initial begin
    test_reset();
    test_read(4'h1, "read_a1");
    test_read(4'hA, "read_aA");
    test_hold();
    test_write();
    test_read(4'hC, "read_aC");
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
